mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 12, memory word-address width.
REQ-002 Parameter: DATA_W, default 16, memory word width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req0/req1  input  1 each  access request from requester 0 (CPU) / requester 1 (DMA/IO).
REQ-006 Port: we0/we1  input  1 each  write enable accompanying req.
REQ-007 Port: lock0/lock1  input  1 each  hold ownership after this access (multi-word sequences, e.g. two-word instructions, push/call).
REQ-008 Port: addr0/addr1  input  ADDR_W each  word address.
REQ-009 Port: wdata0/wdata1  input  DATA_W each  write data.
REQ-010 Port: gnt0/gnt1  output  1 each  access accepted this cycle (combinational).
REQ-011 Port: rvalid0/rvalid1  output  1 each  read data valid, one cycle after granted read.
REQ-012 Port: rdata  output  DATA_W  read data, shared by both requesters, qualified by rvalid0/rvalid1.
REQ-013 Port: mem_addr/mem_wdata/mem_we  output  ADDR_W/DATA_W/1  single-port synchronous memory request.
REQ-014 Port: mem_rdata  input  DATA_W  memory read data, valid one cycle after the address.

Function
REQ-015 At most one gnt SHALL be high per cycle; gntN high only when reqN is high.
REQ-016 Memory outputs SHALL carry the granted requester's addr/wdata; mem_we = granted weN; no grant -> mem_we=0, mem_addr/mem_wdata = requester 0 values.
REQ-017 FSM states SHALL be: IDLE (no owner), OWN0, OWN1 (locked owner).
REQ-018 IDLE, single request -> grant that requester.
REQ-019 IDLE, both request -> grant the requester not recorded in last-grant pointer (round-robin); pointer updates to the granted one on every grant.
REQ-020 Grant with lockN=1 -> next state OWNN; grant with lockN=0 -> IDLE.
REQ-021 OWNN: only requester N SHALL be granted, regardless of the other's request; stays OWNN while granted with lockN=1; returns IDLE on a grant with lockN=0.
REQ-022 OWNN with reqN=0 SHALL keep ownership, grant nothing, and count idle cycles in a 4-bit counter; counter reaching 15 SHALL force IDLE (deadlock release); counter clears on any grant or state change.
REQ-023 rvalidN SHALL be registered: high exactly one cycle after a cycle with gntN=1 and weN=0; rdata = mem_rdata passthrough.
REQ-024 Writes SHALL produce no rvalid.
REQ-025 Back-to-back grants SHALL be accepted every cycle (throughput one access per cycle); a read's rvalid may coincide with the next grant.
REQ-026 Address width SHALL not be extended or truncated; no arithmetic on addresses.

Reset
REQ-027 reset high SHALL immediately force: state IDLE, last-grant pointer = requester 1 (requester 0 wins first tie), rvalid0=rvalid1=0, idle counter 0.
REQ-028 gnt0/gnt1 and mem_we SHALL be 0 while reset is high; an in-flight read's rvalid is discarded.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, OWN0, OWN1), ADDR_W/DATA_W defaults, and the idle-timeout constant (15).
REQ-030 No sub-module; one always_ff block for state/pointer/counter/rvalid, one always_comb block for grant and memory mux.

Verification
REQ-031 After reset, req0=req1=1, we=0, locks 0, held 4 cycles -> gnt sequence 0,1,0,1; rvalid follows each by one cycle with matching port.
REQ-032 req0=1 lock0=1 addr0=0x010 two cycles, then lock0=0, with req1=1 throughout -> gnt0 three cycles, gnt1 on fourth cycle.
REQ-033 Requester 1 write addr1=0x0A5 wdata1=0x1234, then requester 0 read 0x0A5 -> mem_we=1 first cycle, rdata=0x1234 with rvalid0=1 two cycles after the write.
REQ-034 OWN0 entered, then req0=0 for 16 cycles with req1=1 -> no grants for 15 cycles, state IDLE, gnt1=1 on the following cycle.
REQ-035 Reset asserted in cycle after a granted read -> rvalid0 stays 0, state IDLE, gnt0/gnt1=0 while reset high.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the ownership state encoding, the default widths and the idle-timeout limit.
package mem_arbiter_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 16;

   // An owner that stays silent this many cycles loses its lock.
   localparam logic [3:0] IDLE_TIMEOUT = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: round-robin on ties,
// lock-based ownership for multi-word sequences, and an idle timeout that releases a stalled lock.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output state_e            dbg_state
);

   // Handshake: reqN is a request held by the requester; gntN (combinational) accepts it in the
   // same cycle. A granted read returns data on rdata one cycle later, qualified by rvalidN.

   state_e     state_q, state_d;
   logic       last_q, last_d;           // 0: requester 0 granted last, 1: requester 1
   logic [3:0] idle_cnt_q, idle_cnt_d;
   logic       rvalid0_q, rvalid0_d;
   logic       rvalid1_q, rvalid1_d;
   logic [3:0] idle_inc;
   logic       g0, g1;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      idle_cnt_d = 4'd0;
      idle_inc   = idle_cnt_q + 4'd1;
      g0         = 1'b0;
      g1         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               g0 = last_q;
               g1 = ~last_q;
            end else begin
               g0 = req0;
               g1 = req1;
            end
         end
         OWN0: begin
            if (req0) begin
               g0 = 1'b1;
            end else if (idle_inc == IDLE_TIMEOUT) begin
               state_d = IDLE;
            end else begin
               idle_cnt_d = idle_inc;
            end
         end
         OWN1: begin
            if (req1) begin
               g1 = 1'b1;
            end else if (idle_inc == IDLE_TIMEOUT) begin
               state_d = IDLE;
            end else begin
               idle_cnt_d = idle_inc;
            end
         end
         default: state_d = IDLE;
      endcase

      // Reset suppresses grants combinationally so nothing reaches memory while it is held.
      if (reset) begin
         g0 = 1'b0;
         g1 = 1'b0;
      end

      if (g0) begin
         last_d     = 1'b0;
         state_d    = lock0 ? OWN0 : IDLE;
         idle_cnt_d = 4'd0;
      end
      if (g1) begin
         last_d     = 1'b1;
         state_d    = lock1 ? OWN1 : IDLE;
         idle_cnt_d = 4'd0;
      end

      rvalid0_d = g0 & ~we0;
      rvalid1_d = g1 & ~we1;

      gnt0      = g0;
      gnt1      = g1;
      mem_addr  = g1 ? addr1 : addr0;
      mem_wdata = g1 ? wdata1 : wdata0;
      mem_we    = (g0 & we0) | (g1 & we1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         idle_cnt_q <= 4'd0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         idle_cnt_q <= idle_cnt_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
      end
   end

   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rdata     = mem_rdata;
   assign dbg_state = state_q;

endmodule
